// File: rtl/tdm_pkg.sv
//============================================================================
// Module : tdm_pkg
// Brief  : Shared types and sizing helpers for the 8:1 TDM receive path.
//          Optional macro TDM_DEMUX_PARITY_EN adds a trailing parity slot.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package tdm_pkg;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int DEF_N_CH = 8;

   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int frame_len(input int n_ch);
`ifdef TDM_DEMUX_PARITY_EN
      return n_ch + 1;
`else
      return n_ch;
`endif
   endfunction

   localparam int FRAME_LEN = frame_len(DEF_N_CH);

endpackage

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
//============================================================================
// Module : tdm_slot_counter
// Brief  : Valid-qualified slot counter with wrap and frame-sync resync.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter int LEN    = 8,
   parameter int SLOT_W = slot_w(LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              sync,
   input  logic              lock,
   output logic [SLOT_W-1:0] slot,
   output logic              last_slot,
   output logic              misplaced_sync
);

   localparam logic [SLOT_W-1:0] C_LAST = SLOT_W'(LEN - 1);
   localparam logic [SLOT_W-1:0] C_ONE  = SLOT_W'(1);

   logic [SLOT_W-1:0] slot_q, slot_d;

   assign slot           = slot_q;
   assign last_slot      = (slot_q == C_LAST);
   assign misplaced_sync = valid & sync & lock & (slot_q != '0);

   // A qualified sync always means "this slot was channel 0", so next is 1.
   always_comb begin
      slot_d = slot_q;
      if (valid) begin
         if (sync) begin
            slot_d = C_ONE;
         end else if (lock) begin
            slot_d = last_slot ? '0 : slot_q + C_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tdm_demux8.sv
//============================================================================
// Module : tdm_demux8
// Brief  : Reassembles serial TDM slots into a parallel frame, channel 0 MSB.
//          TDM_DEMUX_PARITY_EN adds a checked XOR parity slot and parity_err.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tdm_demux8
   import tdm_pkg::*;
#(
   parameter  int N_CH   = 8,
   parameter  int W      = 1,
   localparam int LEN    = frame_len(N_CH),
   localparam int SLOT_W = slot_w(LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [N_CH*W-1:0] dout,
   output logic              dout_valid,
   output logic [SLOT_W-1:0] slot,
   output logic              locked,
   output logic              sync_err
`ifdef TDM_DEMUX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   state_e              state_q, state_d;
   logic [N_CH*W-1:0]   shadow_q, shadow_d;
   logic [N_CH*W-1:0]   dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                sync_err_q, sync_err_d;
   logic [N_CH*W-1:0]   frame_w;
   logic [SLOT_W-1:0]   cnt_slot;
   logic                last_slot;
   logic                misplaced;

`ifdef TDM_DEMUX_PARITY_EN
   logic                parity_err_q, parity_err_d;
   logic [W-1:0]        parity_w;
`endif

   tdm_slot_counter #(
      .LEN    (LEN),
      .SLOT_W (SLOT_W)
   ) u_slot_counter (
      .clk            (clk),
      .rst            (rst),
      .valid          (din_valid),
      .sync           (frame_sync),
      .lock           (state_q == LOCKED),
      .slot           (cnt_slot),
      .last_slot      (last_slot),
      .misplaced_sync (misplaced)
   );

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_d = 1'b0;
      parity_w     = '0;
      for (int k = 0; k < N_CH; k++) begin
         parity_w = parity_w ^ shadow_q[(N_CH-k)*W-1 -: W];
      end
`endif
      // Shadow with the current slot merged in; lets the last slot load dout directly.
      frame_w = shadow_q;
      for (int k = 0; k < N_CH; k++) begin
         if (SLOT_W'(k) == cnt_slot) begin
            frame_w[(N_CH-k)*W-1 -: W] = din;
         end
      end

      if (din_valid) begin
         if (frame_sync) begin
            shadow_d                  = '0;
            shadow_d[N_CH*W-1 -: W]   = din;
            state_d                   = LOCKED;
            sync_err_d                = misplaced;
         end else if (state_q == LOCKED) begin
            shadow_d = frame_w;
            if (last_slot) begin
`ifdef TDM_DEMUX_PARITY_EN
               if (parity_w == din) begin
                  dout_d       = shadow_q;
                  dout_valid_d = 1'b1;
               end else begin
                  parity_err_d = 1'b1;
               end
`else
               dout_d       = frame_w;
               dout_valid_d = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         shadow_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign slot       = cnt_slot;
   assign locked     = (state_q == LOCKED);
   assign sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire
